rr_req_queue: RTL
=================

Name: rr_req_queue

Overview:
- Four-channel request front end for the 4-way round-robin arbiter.
- Each channel buffers incoming words in its own small FIFO and drives REQ[i] while that FIFO holds data.
- The one-hot GNT returned by the arbiter pops the granted channel's head word into a single registered valid/ready output, tagged with its source ID.
- Sits between the traffic sources and the shared sink. The arbiter is a sibling block wired through REQ/GNT.

Parameters:
- DW, 8, data width per channel in bits.
- DEPTH, 4, entries per channel FIFO; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  input  4  per-channel write strobe.
- in_data  input  4*DW  channel i occupies bits [i*DW +: DW].
- in_ready  output  4  per-channel space available; equals not-full.
- REQ  output  4  request vector to the arbiter.
- GNT  input  4  grant vector from the arbiter; expected one-hot or zero.
- out_valid  output  1  output word valid.
- out_data  output  DW  output word.
- out_id  output  2  source channel of out_data.
- out_ready  input  1  sink accepts the word when out_valid and out_ready are both high.
- gnt_err  output  1  sticky flag: a multi-hot GNT was seen.

Behaviour:
- Reset (rst_n low at a rising edge): all FIFOs empty, pointers and counts 0.
  - out_valid=0, out_data=0, out_id=0, gnt_err=0.
  - in_ready=4'b1111 and REQ=4'b0000 from the cycle after the reset edge.
- Reset mid-operation: all buffered and in-flight words are discarded. No partial state survives.
- Push: when in_valid[i] && in_ready[i], in_data slice i is written at the FIFO i tail.
  - in_ready[i]=0 when count[i]==DEPTH.
  - No bypass: a push to a full FIFO is ignored even if a pop of that FIFO happens in the same cycle.
- Output slot free: slot_free = !out_valid || out_ready (combinational).
- REQ[i] = (count[i]!=0) && slot_free.
  - Requests are withdrawn while the output is stalled, so grants are never wasted.
- Pop: when slot_free, GNT is one-hot with bit i set, and count[i]!=0:
  - FIFO i head moves to out_data; out_id=i; out_valid=1 on the next edge.
  - FIFO i read pointer advances.
  - Latency: a word pushed at edge N can appear on out_valid at edge N+2 at the earliest. REQ rises after edge N; GNT returns in cycle N+1, per the arbiter's registered grant.
- Ignored GNT (no pop, no state change):
  - grant to an empty channel (stale grant);
  - grant while !slot_free;
  - GNT==0.
- Multi-hot GNT: no pop; gnt_err set to 1 and held until reset.
- Output handshake: out_data and out_id hold stable while out_valid && !out_ready.
  - out_valid clears on acceptance unless a new pop loads the slot in the same cycle. Back-to-back words are permitted: one word per cycle at full throughput.
- Simultaneous push and pop on the same channel with count in 1..DEPTH-1: both occur; count unchanged.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Word ordering: strict FIFO order within a channel. No ordering guarantee across channels; cross-channel order is set by the arbiter.

Test Plan:
- Reset then idle → in_ready=4'b1111, REQ=0, out_valid=0, gnt_err=0. Drive GNT=4'b0100 → no output, no state change.
- Push 0x11 on ch3 at edge N; model grant GNT=4'b1000 in cycle N+1 → out_valid=1, out_data=0x11, out_id=3 after edge N+2; REQ[3]=0 afterwards.
- Fill ch1 with 0xA0..0xA3 (4 pushes) → in_ready[1]=0. A 5th push of 0xA4 is dropped. Grant ch1 four times → output sequence 0xA0,0xA1,0xA2,0xA3, then REQ[1]=0.
- Hold out_ready=0 with out_valid=1 (data 0x55, id 2) and ch0 non-empty → REQ=0; GNT=4'b0001 is ignored; out_data stays 0x55. Raise out_ready → next pop is ch0's head.
- Drive GNT=4'b0110 with ch1 and ch2 non-empty → no pop; gnt_err=1 and stays 1 until rst_n=0, which also clears out_valid and every FIFO.
- Continuous push on ch2 while ch2 is granted every cycle, out_ready=1 → one word out per cycle in push order; count[2] constant; pointers wrap past DEPTH with no loss.

Source files
------------

// File: rtl/rr_req_queue.sv
// Four-channel request queue feeding a round-robin arbiter: per-channel FIFOs
// raise REQ, and a one-hot GNT pops the granted head into a registered output.
module rr_req_queue #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      in_valid,
  input  logic [4*DW-1:0] in_data,
  output logic [3:0]      in_ready,
  output logic [3:0]      REQ,
  input  logic [3:0]      GNT,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [1:0]      out_id,
  input  logic            out_ready,
  output logic            gnt_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem    [4][DEPTH];
  logic [AW-1:0] wr_ptr [4];
  logic [AW-1:0] rd_ptr [4];
  logic [CW-1:0] count  [4];

  logic          slot_free;
  logic          gnt_multi;
  logic          gnt_one_hot;
  logic [3:0]    push;
  logic [3:0]    pop;
  logic          pop_any;
  logic [1:0]    pop_id;
  logic [DW-1:0] pop_data;

  always_comb begin
    slot_free   = !out_valid || out_ready;
    gnt_multi   = (GNT & (GNT - 4'd1)) != '0;
    gnt_one_hot = (GNT != '0) && !gnt_multi;
    in_ready    = '0;
    REQ         = '0;
    push        = '0;
    pop         = '0;
    pop_id      = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      in_ready[i] = count[i] != CW'(DEPTH);
      REQ[i]      = (count[i] != '0) && slot_free;
      // Push qualifies on pre-pop fullness: no bypass into a full FIFO.
      push[i]     = in_valid[i] && in_ready[i];
      pop[i]      = slot_free && gnt_one_hot && GNT[i] && (count[i] != '0);
      if (GNT[i]) pop_id = 2'(i);
    end
    pop_any  = |pop;
    pop_data = mem[pop_id][rd_ptr[pop_id]];
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (rst_n && push[i]) mem[i][wr_ptr[i]] <= in_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      gnt_err   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + CW'(1);
        else if (!push[i] && pop[i]) count[i] <= count[i] - CW'(1);
      end
      if (pop_any) begin
        out_valid <= 1'b1;
        out_data  <= pop_data;
        out_id    <= pop_id;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (gnt_multi) gnt_err <= 1'b1;
    end
  end

endmodule
